veda_mem_arbiter: RTL and testbench
===================================

Name: veda_mem_arbiter

Overview:
- Arbitrates the single-port 512x32 unified instruction/data memory between three requesters: host program loader (port 0), core load/store unit (port 1) and core instruction fetch (port 2).
- Fixed priority, with a starvation guard on ports 1 and 2 and a host lock for exclusive burst program loads.
- Sits between the core/loader and the memory macro.
- Replaces the core driving memory address/write-enable directly.

Parameters:
- AW, 9, memory address width (512 words).
- DW, 32, data width.
- MAX_WAIT, 4, consecutive denied request cycles after which port 1 or port 2 is forced to win; range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0/req1/req2  input  1 each  access request, held until granted.
- we0/we1/we2  input  1 each  1 = write, 0 = read; valid while reqN.
- addr0/addr1/addr2  input  AW each  word address; valid while reqN.
- wdata0/wdata1/wdata2  input  DW each  write data; valid while reqN & weN.
- host_lock  input  1  host requests exclusive ownership.
- gnt0/gnt1/gnt2  output  1 each  combinational grant, one-hot or zero; access accepted at the clock edge where reqN & gntN.
- rvalid0/rvalid1/rvalid2  output  1 each  registered; pulses one cycle after an accepted read on that port.
- rdata  output  DW  shared read data = mem_rdata; qualified by rvalidN.
- mem_en  output  1  memory access strobe (= any gnt).
- mem_we  output  1  write strobe of the granted port.
- mem_addr  output  AW  address of the granted port.
- mem_wdata  output  DW  write data of the granted port.
- mem_rdata  input  DW  memory read data, valid one cycle after a read strobe.
- locked  output  1  registered; host lock currently held.

Behaviour:
- Reset (rst=1 at the edge):
  - wait1, wait2 := 0; locked := 0; rvalid0..2 := 0; pending read state cleared.
  - While rst is high, gnt0..2, mem_en and mem_we are forced to 0.
  - A read accepted in the cycle before reset produces no rvalid.
- Arbitration, combinational, evaluated each cycle:
  - If locked=1: only port 0 can be granted; gnt1 = gnt2 = 0 regardless of wait counters.
  - Else if wait1==MAX_WAIT and req1: grant port 1.
  - Else if wait2==MAX_WAIT and req2: grant port 2.
  - Else fixed priority among requesting ports: 0 > 1 > 2.
  - No request: all grants 0, mem_en = 0; mem_addr, mem_wdata and mem_we = 0.
- Wait counters (ports 1 and 2), updated at each edge:
  - reqN & !gntN: increment, saturating at MAX_WAIT.
  - gntN or !reqN: clear to 0.
- Lock, updated at each edge:
  - locked := 1 at an edge where req0 & gnt0 & host_lock.
  - locked := 0 at any edge where host_lock = 0.
  - A lock already held stays held across cycles where req0 = 0, as long as host_lock = 1.
- Latency and read return:
  - Write: memory written at the accept edge; zero-cycle grant.
  - Read: mem_en & !mem_we at edge T means mem_rdata is valid during cycle T+1, and rvalidN = 1 in cycle T+1 only.
- Throughput:
  - One access per cycle; back-to-back grants to different ports allowed.
  - rvalid of consecutive reads appear on consecutive cycles in grant order.
- Requester rule: addr/we/wdata must stay stable while reqN=1 & gntN=0. The arbiter does not latch them.
- Simultaneous events:
  - Both counters saturated: port 1 wins. Port 2 stays saturated and wins the next cycle unless port 1 saturates again first (port 1's counter has just been cleared, so it cannot).
  - host_lock deasserted in the same cycle as req1: lock clears at that edge, so port 1 can first be granted in the following cycle.
- Invariants (checked by assertions):
  - At most one gnt per cycle.
  - gntN implies reqN.
  - mem_en == |{gnt0, gnt1, gnt2}.
  - At most one rvalid per cycle.

Test Plan:
- Reset/idle: rst high for 2 cycles with req0..2 = 1 -> all gnt = 0, mem_en = 0, rvalid = 0. After release, gnt0 = 1 in the first cycle.
- Read latency: req2 = 1, we2 = 0, addr2 = 5, memory word 5 = 32'h5C08_0000 -> gnt2 in the same cycle; rvalid2 = 1 with rdata = 32'h5C08_0000 the next cycle; then rvalid2 returns to 0.
- Priority and back-to-back: req1 (sw addr 100, data 90) and req2 (fetch addr 7) in the same cycle -> gnt1 first (write done); gnt2 the next cycle; rvalid2 one cycle later.
- Starvation, MAX_WAIT = 4: req0 held continuously, req2 held -> gnt0 for 4 cycles; gnt2 in the 5th cycle; wait2 back to 0; gnt0 resumes.
- Host lock: req0 + host_lock for a 10-word burst to addresses 0..9, with req1 and req2 held -> gnt1 = gnt2 = 0 throughout, even after 4 or more cycles. Drop host_lock -> gnt1 the next cycle, then gnt2.
- Reset mid-read: read accepted on port 1 at edge T, rst = 1 at edge T+1 -> rvalid1 = 0 after the T+1 edge. All counters and locked are 0.

Source files
------------

// File: rtl/veda_mem_arbiter.sv
// veda_mem_arbiter: arbitrates a single-port unified instruction/data memory
// between the host program loader (port 0), the core load/store unit (port 1)
// and the core instruction fetch (port 2). Fixed priority 0 > 1 > 2, with a
// starvation guard on ports 1 and 2, and a host lock that keeps ports 1 and 2
// out for the whole of an exclusive burst program load.
module veda_mem_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          req2,
  input  logic          we0,
  input  logic          we1,
  input  logic          we2,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  input  logic          host_lock,
  output logic          gnt0,
  output logic          gnt1,
  output logic          gnt2,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          rvalid2,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          locked
);

  // Wait counters are wide enough for the largest legal MAX_WAIT (15).
  localparam int            WW    = 4;
  localparam logic [WW-1:0] C_MAX = WW'(MAX_WAIT);

  logic [2:0]    w_gnt;
  logic [WW-1:0] r_wait1;
  logic [WW-1:0] r_wait2;
  logic          r_locked;
  logic [2:0]    r_rvalid;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  // Grant selection: lock first, then starvation guard (port 1 before port 2),
  // then plain fixed priority. Nothing is granted while reset is asserted.
  always_comb begin
    w_gnt = 3'b000;
    if (rst) begin
      w_gnt = 3'b000;
    end else if (r_locked) begin
      w_gnt = {2'b00, req0};
    end else if ((r_wait1 == C_MAX) && req1) begin
      w_gnt = 3'b010;
    end else if ((r_wait2 == C_MAX) && req2) begin
      w_gnt = 3'b100;
    end else if (req0) begin
      w_gnt = 3'b001;
    end else if (req1) begin
      w_gnt = 3'b010;
    end else if (req2) begin
      w_gnt = 3'b100;
    end else begin
      w_gnt = 3'b000;
    end
  end

  // Route the granted port's command onto the memory bus; idle bus is all zero.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = {AW{1'b0}};
    w_mem_wdata = {DW{1'b0}};
    case (w_gnt)
      3'b001: begin
        w_mem_we    = we0;
        w_mem_addr  = addr0;
        w_mem_wdata = wdata0;
      end
      3'b010: begin
        w_mem_we    = we1;
        w_mem_addr  = addr1;
        w_mem_wdata = wdata1;
      end
      3'b100: begin
        w_mem_we    = we2;
        w_mem_addr  = addr2;
        w_mem_wdata = wdata2;
      end
      default: begin
        w_mem_we    = 1'b0;
        w_mem_addr  = {AW{1'b0}};
        w_mem_wdata = {DW{1'b0}};
      end
    endcase
  end

  // Starvation counters: count denied request cycles, saturate, clear on grant or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait1 <= {WW{1'b0}};
      r_wait2 <= {WW{1'b0}};
    end else begin
      if (req1 && !w_gnt[1]) begin
        r_wait1 <= (r_wait1 == C_MAX) ? r_wait1 : r_wait1 + 4'd1;
      end else begin
        r_wait1 <= {WW{1'b0}};
      end
      if (req2 && !w_gnt[2]) begin
        r_wait2 <= (r_wait2 == C_MAX) ? r_wait2 : r_wait2 + 4'd1;
      end else begin
        r_wait2 <= {WW{1'b0}};
      end
    end
  end

  // Host lock: taken on an accepted host access with host_lock, dropped as soon as host_lock falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked <= 1'b0;
    end else if (!host_lock) begin
      r_locked <= 1'b0;
    end else if (req0 && w_gnt[0]) begin
      r_locked <= 1'b1;
    end else begin
      r_locked <= r_locked;
    end
  end

  // Read return tracking: remember which port had a read accepted this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 3'b000;
    end else begin
      r_rvalid <= w_gnt & {~we2, ~we1, ~we0};
    end
  end

  assign gnt0      = w_gnt[0];
  assign gnt1      = w_gnt[1];
  assign gnt2      = w_gnt[2];
  assign mem_en    = |w_gnt;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;
  assign rdata     = mem_rdata;
  assign locked    = r_locked;
  // A read accepted just before reset must not surface while reset is held.
  assign rvalid0   = r_rvalid[0] & ~rst;
  assign rvalid1   = r_rvalid[1] & ~rst;
  assign rvalid2   = r_rvalid[2] & ~rst;

endmodule

// File: tb/tb_veda_mem_arbiter.sv
// Directed self-checking bench for veda_mem_arbiter with a behavioural
// memory, a reference memory image and a read-return scoreboard.
module tb_veda_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, req2;
  logic          we0, we1, we2;
  logic [AW-1:0] addr0, addr1, addr2;
  logic [DW-1:0] wdata0, wdata1, wdata2;
  logic          host_lock;
  logic          gnt0, gnt1, gnt2;
  logic          rvalid0, rvalid1, rvalid2;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          locked;

  logic          mem_load;
  logic [DW-1:0] mem     [0:511];
  logic [DW-1:0] ref_mem [0:511];
  logic [33:0]   sb_q [$];
  int            n_assert = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  veda_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .req2(req2),
    .we0(we0), .we1(we1), .we2(we2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .host_lock(host_lock),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .locked(locked)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 32'h5C08_0000;
    return 32'hA000_0000 | DW'(a);
  endfunction

  // Behavioural single-port memory: write at the accept edge, read data next cycle.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [2:0] exp);
    chk(tag, {61'd0, gnt2, gnt1, gnt0}, {61'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_rd(input logic [1:0] port, input logic [AW-1:0] a);
    sb_q.push_back({port, ref_mem[a]});
  endtask

  // Read-return monitor: every rvalid pops the scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [2:0]  rv;
    logic [1:0]  port;
    logic [33:0] e;
    rv = {rvalid2, rvalid1, rvalid0};
    if (rv != 3'b000) begin
      chk("rvalid_onehot", {61'd0, rv}, {61'd0, rv & (~rv + 3'd1)});
      port = rv[0] ? 2'd0 : (rv[1] ? 2'd1 : 2'd2);
      if (sb_q.size() == 0) begin
        chk("rvalid_unexpected", {61'd0, rv}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rd_port", {62'd0, port}, {62'd0, e[33:32]});
        chk("rd_data", {32'd0, rdata}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; mem_load = 1'b1; host_lock = 1'b0;
    req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
    we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    addr0 = 9'd1; addr1 = 9'd2; addr2 = 9'd3;
    wdata0 = 32'd0; wdata1 = 32'd0; wdata2 = 32'd0;

    // Reset with all requests raised
    for (int c = 0; c < 2; c++) begin
      settle();
      chk_gnt("rst_gnt", 3'b000);
      chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
      chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
      chk("rst_rvalid", {61'd0, rvalid2, rvalid1, rvalid0}, 64'd0);
      tick();
    end
    rst = 1'b0; mem_load = 1'b0;
    settle();
    chk_gnt("post_rst_gnt0", 3'b001);
    chk("post_rst_locked", {63'd0, locked}, 64'd0);
    push_rd(2'd0, 9'd1);
    tick();
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    settle();
    chk_gnt("idle_gnt", 3'b000);
    chk("idle_addr", {55'd0, mem_addr}, 64'd0);
    tick();

    // Read latency on port 2
    req2 = 1'b1; we2 = 1'b0; addr2 = 9'd5;
    settle();
    chk_gnt("rd_gnt2", 3'b100);
    chk("rd_bus", {54'd0, mem_en, mem_we, mem_addr}, {54'd0, 1'b1, 1'b0, 9'd5});
    push_rd(2'd2, 9'd5);
    tick();
    req2 = 1'b0;
    chk("rd_rvalid2", {63'd0, rvalid2}, 64'd1);
    chk("rd_rdata", {32'd0, rdata}, {32'd0, 32'h5C08_0000});
    tick();
    chk("rd_rvalid2_drop", {63'd0, rvalid2}, 64'd0);

    // Priority: store on port 1 beats fetch on port 2, back to back
    req1 = 1'b1; we1 = 1'b1; addr1 = 9'd100; wdata1 = 32'd90;
    req2 = 1'b1; we2 = 1'b0; addr2 = 9'd7;
    settle();
    chk_gnt("pri_gnt1", 3'b010);
    chk("pri_wr_bus", {22'd0, mem_we, mem_addr, mem_wdata}, {22'd0, 1'b1, 9'd100, 32'd90});
    ref_mem[100] = 32'd90;
    tick();
    req1 = 1'b0;
    settle();
    chk_gnt("pri_gnt2", 3'b100);
    push_rd(2'd2, 9'd7);
    tick();
    req2 = 1'b0;
    chk("pri_rvalid2", {63'd0, rvalid2}, 64'd1);
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'd100;
    settle();
    chk_gnt("readback_gnt1", 3'b010);
    push_rd(2'd1, 9'd100);
    tick();
    req1 = 1'b0;
    tick();

    // Starvation guard on port 2 against a continuous host stream
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'd200; wdata0 = 32'h0000_1234;
    req2 = 1'b1; we2 = 1'b0; addr2 = 9'd9;
    ref_mem[200] = 32'h0000_1234;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk_gnt("starve_gnt0", 3'b001);
      tick();
    end
    settle();
    chk_gnt("starve_gnt2", 3'b100);
    push_rd(2'd2, 9'd9);
    tick();
    req2 = 1'b0;
    settle();
    chk_gnt("starve_resume", 3'b001);
    tick();

    // Both counters saturated: port 1 first, port 2 the next cycle
    req1 = 1'b1; we1 = 1'b1; addr1 = 9'd300; wdata1 = 32'h0000_0011;
    req2 = 1'b1; we2 = 1'b0; addr2 = 9'd10;
    ref_mem[300] = 32'h0000_0011;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk_gnt("both_gnt0", 3'b001);
      tick();
    end
    settle();
    chk_gnt("both_gnt1", 3'b010);
    tick();
    req1 = 1'b0;
    settle();
    chk_gnt("both_gnt2", 3'b100);
    push_rd(2'd2, 9'd10);
    tick();
    req2 = 1'b0;
    settle();
    chk_gnt("both_gnt0_after", 3'b001);
    tick();
    req0 = 1'b0;
    tick();

    // Host lock burst with ports 1 and 2 held off
    host_lock = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'd300;
    req2 = 1'b1; we2 = 1'b0; addr2 = 9'd5;
    req0 = 1'b1; we0 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      addr0 = AW'(c); wdata0 = 32'hB000_0000 | DW'(c);
      ref_mem[c] = 32'hB000_0000 | DW'(c);
      settle();
      chk_gnt("lock_burst_gnt0", 3'b001);
      if (c > 0) chk("lock_held", {63'd0, locked}, 64'd1);
      tick();
    end
    req0 = 1'b0;
    settle();
    chk_gnt("lock_idle_gnt", 3'b000);
    chk("lock_idle_locked", {63'd0, locked}, 64'd1);
    tick();
    host_lock = 1'b0;
    settle();
    chk_gnt("unlock_edge_gnt", 3'b000);
    tick();
    chk("unlocked", {63'd0, locked}, 64'd0);
    chk_gnt("unlock_gnt1", 3'b010);
    push_rd(2'd1, 9'd300);
    tick();
    req1 = 1'b0;
    settle();
    chk_gnt("unlock_gnt2", 3'b100);
    push_rd(2'd2, 9'd5);
    tick();
    req2 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'd3;
    settle();
    chk_gnt("burst_readback_gnt1", 3'b010);
    push_rd(2'd1, 9'd3);
    tick();
    req1 = 1'b0;
    tick();

    // Reset right after an accepted read on port 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'd8;
    settle();
    chk_gnt("rstrd_gnt1", 3'b010);
    tick();
    req1 = 1'b0; rst = 1'b1;
    tick();
    chk("rstrd_rvalid1", {63'd0, rvalid1}, 64'd0);
    chk("rstrd_locked", {63'd0, locked}, 64'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
